par_sink_arbiter: RTL and testbench

PAR_SINK_ARBITER -- requirements
Module: par_sink_arbiter

---
 rtl/par_sink_arbiter_if.sv | 59 +++++
 rtl/par_sink_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_par_sink_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/par_sink_arbiter_if.sv
// ---------------------------------------------------------------------------
// par_sink_arbiter_if
// Bundle of the four requester channels and the single sink channel that
// par_sink_arbiter sits between.
//
// Handshake (both sides): an item moves on a posedge where valid=1 and busy=0.
// A source keeps its item and valid stable while it sees busy=1.
//
// Signals
//   item_in0..3 / valid0..3 : requester items and valids   (master -> slave)
//   busy0..3                : per-requester busy            (slave  -> master)
//   item_out / valid_out    : item presented to the sink    (slave  -> master)
//   busy_in                 : sink channel busy             (master -> slave)
// Item layout: item[W-1:ADDR_BITS] = payload, item[ADDR_BITS-1:0] = address.
// ---------------------------------------------------------------------------
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

interface par_sink_arbiter_if #(
    parameter int W = `PAYLOAD_SIZE + `ADDR_BITS
);
    logic [W-1:0] item_in0;
    logic [W-1:0] item_in1;
    logic [W-1:0] item_in2;
    logic [W-1:0] item_in3;
    logic         valid0;
    logic         valid1;
    logic         valid2;
    logic         valid3;
    logic         busy0;
    logic         busy1;
    logic         busy2;
    logic         busy3;
    logic [W-1:0] item_out;
    logic         valid_out;
    logic         busy_in;

    // Environment side: drives the requesters and the sink's busy.
    modport master (
        output item_in0, item_in1, item_in2, item_in3,
        output valid0, valid1, valid2, valid3,
        output busy_in,
        input  busy0, busy1, busy2, busy3,
        input  item_out, valid_out
    );

    // Arbiter side.
    modport slave (
        input  item_in0, item_in1, item_in2, item_in3,
        input  valid0, valid1, valid2, valid3,
        input  busy_in,
        output busy0, busy1, busy2, busy3,
        output item_out, valid_out
    );
endinterface

// File: rtl/par_sink_arbiter.sv
// ---------------------------------------------------------------------------
// par_sink_arbiter
// Four-requester round-robin arbiter feeding one sink through a single
// output register. Optional burst locking keeps a granted requester for up
// to `burst` consecutive grants; an optional address check flags items whose
// destination address does not match the sink's id.
//
// Ports
//   clk             : clock, all state updates on posedge
//   reset           : asynchronous, active-high reset
//   bus (slave)     : requester channels + sink channel, see par_sink_arbiter_if
//   err_misroute    : sticky flag, set when a forwarded item had a wrong address
//   xfer_count      : number of items delivered to the sink (wraps at 16 bits)
//   o_dbg_state     : FSM state (0 = IDLE, 1 = LOCK)
//   o_dbg_burst_cnt : grants given to the locked requester so far
//   o_dbg_ptr       : last granted port (round-robin pointer)
//
// Parameters
//   id    : sink address; -1 disables the address check
//   burst : max consecutive grants to one requester (1..15)
// ---------------------------------------------------------------------------
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module par_sink_arbiter #(
    parameter int id    = -1,
    parameter int burst = 1
) (
    input  logic              clk,
    input  logic              reset,
    par_sink_arbiter_if.slave bus,
    output logic              err_misroute,
    output logic [15:0]       xfer_count,
    output logic              o_dbg_state,
    output logic [3:0]        o_dbg_burst_cnt,
    output logic [1:0]        o_dbg_ptr
);
    localparam int          AB       = `ADDR_BITS;
    localparam int          W        = `PAYLOAD_SIZE + `ADDR_BITS;
    localparam logic [3:0]  BURST_L  = 4'(burst);
    localparam bit          LOCK_EN  = (burst > 1);
    localparam bit          CHECK_EN = (id != -1);
    localparam logic [31:0] ID_VEC   = id;
    localparam logic [AB-1:0] ID_ADDR = ID_VEC[AB-1:0];

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    // Registers
    state_t        r_state;
    logic [3:0]    r_burst_cnt;
    logic [1:0]    r_lock_port;
    logic [1:0]    r_ptr;
    logic [W-1:0]  r_out_reg;
    logic          r_out_full;
    logic [15:0]   r_xfer_count;
    logic          r_err;

    // Combinational
    logic [W-1:0]  w_item [4];
    logic [3:0]    w_valid;
    logic          w_rr_found;
    logic [1:0]    w_rr_idx;
    logic [1:0]    w_cand;
    logic          w_lock_hold;
    logic          w_win_valid;
    logic [1:0]    w_win_idx;
    logic [W-1:0]  w_win_item;
    logic [AB-1:0] w_win_addr;
    logic          w_acc;
    logic          w_accept;
    logic          w_out_xfer;

    assign w_item[0] = bus.item_in0;
    assign w_item[1] = bus.item_in1;
    assign w_item[2] = bus.item_in2;
    assign w_item[3] = bus.item_in3;
    assign w_valid   = {bus.valid3, bus.valid2, bus.valid1, bus.valid0};

    // Round-robin search starting one past the last granted port. The k=4
    // step wraps back to r_ptr itself, so the last winner is tried last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = 2'd0;
        w_cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_rr_found && w_valid[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    // While locked, the lock owner wins outright as long as it still has an
    // item and has not used up its burst; otherwise fall back to round-robin.
    assign w_lock_hold = (r_state == S_LOCK) && w_valid[r_lock_port] &&
                         (r_burst_cnt < BURST_L);
    assign w_win_valid = w_lock_hold || w_rr_found;
    assign w_win_idx   = w_lock_hold ? r_lock_port : w_rr_idx;
    assign w_win_item  = w_item[w_win_idx];
    assign w_win_addr  = w_win_item[AB-1:0];

    // The output register can take a new item if it is empty or is being
    // emptied on this same edge.
    assign w_acc      = !r_out_full || !bus.busy_in;
    assign w_accept   = w_acc && w_win_valid;
    assign w_out_xfer = r_out_full && !bus.busy_in;

    assign bus.busy0 = !(w_accept && (w_win_idx == 2'd0));
    assign bus.busy1 = !(w_accept && (w_win_idx == 2'd1));
    assign bus.busy2 = !(w_accept && (w_win_idx == 2'd2));
    assign bus.busy3 = !(w_accept && (w_win_idx == 2'd3));

    assign bus.item_out  = r_out_reg;
    assign bus.valid_out = r_out_full;

    assign err_misroute    = r_err;
    assign xfer_count      = r_xfer_count;
    assign o_dbg_state     = r_state;
    assign o_dbg_burst_cnt = r_burst_cnt;
    assign o_dbg_ptr       = r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_burst_cnt  <= 4'd0;
            r_lock_port  <= 2'd0;
            r_ptr        <= 2'd3;
            r_out_reg    <= '0;
            r_out_full   <= 1'b0;
            r_xfer_count <= 16'd0;
            r_err        <= 1'b0;
        end else begin
            // Output register: a new accept wins over the plain drain case,
            // which lets delivery and refill happen on the same edge.
            if (w_accept) begin
                r_out_reg  <= w_win_item;
                r_out_full <= 1'b1;
                r_ptr      <= w_win_idx;
            end else if (w_out_xfer) begin
                r_out_full <= 1'b0;
            end

            if (w_out_xfer) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end

            // Misrouted items are still forwarded; only the flag records it.
            if (w_accept && CHECK_EN && (w_win_addr != ID_ADDR)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept && LOCK_EN) begin
                        r_state     <= S_LOCK;
                        r_lock_port <= w_win_idx;
                        r_burst_cnt <= 4'd1;
                    end
                end
                S_LOCK: begin
                    // Backpressure (w_acc=0) freezes the lock as it is.
                    if (w_acc) begin
                        if (w_lock_hold) begin
                            r_burst_cnt <= r_burst_cnt + 4'd1;
                        end else if (w_accept) begin
                            // Lock released; the round-robin winner of this
                            // same cycle immediately starts a fresh lock.
                            r_lock_port <= w_win_idx;
                            r_burst_cnt <= 4'd1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_burst_cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_burst_cnt <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_par_sink_arbiter.sv
// ---------------------------------------------------------------------------
// tb_par_sink_arbiter
// Two arbiters: u_a (burst=1, no address check) and u_b (burst=3, id=2).
// Directed stimulus pushes the hand-derived item order into a per-instance
// expected queue; a negedge monitor pops and compares every item delivered
// to the sink. Register/flag values are checked directly in the stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module tb_par_sink_arbiter;
    localparam int PS = `PAYLOAD_SIZE;
    localparam int AB = `ADDR_BITS;
    localparam int W  = PS + AB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    par_sink_arbiter_if bus_a ();
    par_sink_arbiter_if bus_b ();

    logic        err_a, err_b;
    logic [15:0] xfer_a, xfer_b;
    logic        st_a, st_b;
    logic [3:0]  cnt_a, cnt_b;
    logic [1:0]  ptr_a, ptr_b;

    par_sink_arbiter #(.id(-1), .burst(1)) u_a (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_a),
        .err_misroute    (err_a),
        .xfer_count      (xfer_a),
        .o_dbg_state     (st_a),
        .o_dbg_burst_cnt (cnt_a),
        .o_dbg_ptr       (ptr_a)
    );

    par_sink_arbiter #(.id(2), .burst(3)) u_b (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus_b),
        .err_misroute    (err_b),
        .xfer_count      (xfer_b),
        .o_dbg_state     (st_b),
        .o_dbg_burst_cnt (cnt_b),
        .o_dbg_ptr       (ptr_b)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus_a.valid_out && !bus_a.busy_in) begin
            if (exp_q_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_item: got %0h expected none at %0t", bus_a.item_out, $time);
            end else begin
                check("a_item_out", 32'(bus_a.item_out), 32'(exp_q_a.pop_front()));
            end
        end
        if (!reset && bus_b.valid_out && !bus_b.busy_in) begin
            if (exp_q_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_item: got %0h expected none at %0t", bus_b.item_out, $time);
            end else begin
                check("b_item_out", 32'(bus_b.item_out), 32'(exp_q_b.pop_front()));
            end
        end
    end

    // ---------------- item helpers ----------------
    function automatic logic [W-1:0] item_a(input int p);
        return {PS'(8'hA0 + p), AB'(p)};
    endfunction

    function automatic logic [W-1:0] item_b(input int p);
        return {PS'(8'hB0 + p), AB'(2)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid_a(input logic [3:0] v);
        bus_a.valid0 = v[0];
        bus_a.valid1 = v[1];
        bus_a.valid2 = v[2];
        bus_a.valid3 = v[3];
    endtask

    task automatic set_valid_b(input logic [3:0] v);
        bus_b.valid0 = v[0];
        bus_b.valid1 = v[1];
        bus_b.valid2 = v[2];
        bus_b.valid3 = v[3];
    endtask

    // Watchdog: the stimulus has no open-ended waits, this only guards the run.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        bus_a.item_in0 = item_a(0);
        bus_a.item_in1 = item_a(1);
        bus_a.item_in2 = item_a(2);
        bus_a.item_in3 = item_a(3);
        bus_b.item_in0 = item_b(0);
        bus_b.item_in1 = item_b(1);
        bus_b.item_in2 = item_b(2);
        bus_b.item_in3 = item_b(3);
        set_valid_a(4'h0);
        set_valid_b(4'h0);
        bus_a.busy_in = 1'b0;
        bus_b.busy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset state
        check("rst_valid_out_a", 32'(bus_a.valid_out), 32'd0);
        check("rst_xfer_a",      32'(xfer_a), 32'd0);
        check("rst_err_a",       32'(err_a), 32'd0);
        check("rst_ptr_a",       32'(ptr_a), 32'd3);
        check("rst_valid_out_b", 32'(bus_b.valid_out), 32'd0);
        check("rst_state_b",     32'(st_b), 32'd0);
        check("rst_cnt_b",       32'(cnt_b), 32'd0);
        check("idle_busy0_b",    32'(bus_b.busy0), 32'd1);
        reset = 1'b0;

        // A: all four valid, burst=1 -> 0,1,2,3,... and xfer_count wrap
        set_valid_a(4'hF);
        #1;
        check("a_first_busy0", 32'(bus_a.busy0), 32'd0);
        check("a_first_busy1", 32'(bus_a.busy1), 32'd1);
        check("a_first_busy3", 32'(bus_a.busy3), 32'd1);
        for (int k = 0; k <= 65536; k++) begin
            exp_q_a.push_back(item_a(k % 4));
            tick();
            if (k == 8)     check("a_xfer_after_9", 32'(xfer_a), 32'd8);
            if (k == 65535) check("a_xfer_max",     32'(xfer_a), 32'd65535);
            if (k == 65536) check("a_xfer_wrap",    32'(xfer_a), 32'd0);
        end
        set_valid_a(4'h0);
        tick();
        check("a_drained_valid", 32'(bus_a.valid_out), 32'd0);
        check("a_drained_xfer",  32'(xfer_a), 32'd1);
        check("a_err_never",     32'(err_a), 32'd0);

        // B: burst=3, ports 0 and 2 -> 0,0,0,2,2,2,0
        set_valid_b(4'b0101);
        exp_q_b.push_back(item_b(0));
        exp_q_b.push_back(item_b(0));
        exp_q_b.push_back(item_b(0));
        exp_q_b.push_back(item_b(2));
        exp_q_b.push_back(item_b(2));
        exp_q_b.push_back(item_b(2));
        exp_q_b.push_back(item_b(0));
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 1) check("b_lock_blocks_rr", 32'(bus_b.busy2), 32'd1);
            if (i == 3) check("b_cnt_full",       32'(cnt_b), 32'd3);
            if (i == 4) check("b_relock_cnt",     32'(cnt_b), 32'd1);
            if (i == 7) check("b_lock_state",     32'(st_b), 32'd1);
        end
        set_valid_b(4'h0);
        tick();
        check("b_burst_valid_out", 32'(bus_b.valid_out), 32'd0);
        check("b_burst_idle",      32'(st_b), 32'd0);
        check("b_burst_xfer",      32'(xfer_b), 32'd7);

        // B: backpressure with port 1 holding
        bus_b.busy_in = 1'b1;
        set_valid_b(4'b0010);
        exp_q_b.push_back(item_b(1));
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_busy1",     32'(bus_b.busy1), 32'd1);
            check("bp_item_out",  32'(bus_b.item_out), 32'(item_b(1)));
            check("bp_xfer_hold", 32'(xfer_b), 32'd7);
            tick();
        end
        check("bp_cnt_hold", 32'(cnt_b), 32'd1);
        bus_b.busy_in = 1'b0;
        exp_q_b.push_back(item_b(1));
        #1;
        check("bp_release_busy1", 32'(bus_b.busy1), 32'd0);
        tick();
        check("bp_release_xfer",  32'(xfer_b), 32'd8);
        check("bp_release_valid", 32'(bus_b.valid_out), 32'd1);
        check("bp_release_cnt",   32'(cnt_b), 32'd2);
        set_valid_b(4'h0);
        tick();
        check("bp_drain_xfer", 32'(xfer_b), 32'd9);
        check("bp_drain_idle", 32'(st_b), 32'd0);

        // B: misroute from port 3 (address 5, sink id 2)
        bus_b.item_in3 = {PS'(8'hB3), AB'(5)};
        set_valid_b(4'b1000);
        #1;
        check("mis_err_before", 32'(err_b), 32'd0);
        exp_q_b.push_back({PS'(8'hB3), AB'(5)});
        tick();
        check("mis_err_set", 32'(err_b), 32'd1);
        set_valid_b(4'h0);
        tick();
        check("mis_forwarded_xfer", 32'(xfer_b), 32'd10);
        check("mis_err_sticky1",    32'(err_b), 32'd1);
        tick();
        check("mis_err_sticky2", 32'(err_b), 32'd1);
        bus_b.item_in3 = item_b(3);

        // B: reset while full and locked; buffered item is discarded
        bus_b.busy_in = 1'b1;
        set_valid_b(4'hF);
        tick();
        check("rl_full",  32'(bus_b.valid_out), 32'd1);
        check("rl_locked", 32'(st_b), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rl_valid_out_now", 32'(bus_b.valid_out), 32'd0);
        check("rl_state_now",     32'(st_b), 32'd0);
        check("rl_xfer_now",      32'(xfer_b), 32'd0);
        check("rl_err_now",       32'(err_b), 32'd0);
        tick();
        reset = 1'b0;
        bus_b.busy_in = 1'b0;
        exp_q_b.push_back(item_b(0));
        #1;
        check("rl_grant0_busy0", 32'(bus_b.busy0), 32'd0);
        check("rl_grant0_busy1", 32'(bus_b.busy1), 32'd1);
        tick();
        set_valid_b(4'h0);
        tick();
        check("rl_after_xfer",  32'(xfer_b), 32'd1);
        check("rl_after_valid", 32'(bus_b.valid_out), 32'd0);

        // leftovers in the expected queues mean items never came out
        tick();
        check("q_empty_a", 32'(exp_q_a.size()), 32'd0);
        check("q_empty_b", 32'(exp_q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
